mipsfpga_ahb_dma: RTL and testbench

- Bus-master (initiator) side of the two-master AHB fabric: a word-copy DMA engine that requests the bus, waits for grant and copies LEN words from SRC to DST.
- Each word is one single read transfer followed by one single write transfer.
- Attaches to master port 1 of the AHB interconnect, alongside the CPU on port 0, and is configured by a local control interface.

---
 rtl/mipsfpga_ahb_dma.sv | 184 ++++++++++++++++++
 tb/tb_mipsfpga_ahb_dma.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mipsfpga_ahb_dma.sv
// mipsfpga_ahb_dma -- word-copy DMA engine, AHB bus master (fabric port 1).
//
// Copies len 32-bit words from src_addr to dst_addr. Every word is one
// SINGLE read followed by one SINGLE write. The bus is requested with
// HBUSREQ and a transfer is only driven while ownership (own) is held.
//
// Ports:
//   HCLK, HRESETn         bus clock, asynchronous active-low reset
//   start                 one-cycle pulse, accepted only when idle
//   src_addr, dst_addr    word-aligned byte addresses latched at start
//   len                   number of words to copy (0 = immediate done)
//   busy                  high from accepted start until done
//   done                  one-cycle pulse at completion or error
//   error                 sticky ERROR-response flag, cleared by next start
//   HADDR..HLOCK          AHB master outputs (SINGLE/word/non-cacheable)
//   HGRANT, HRDATA,
//   HREADY, HRESP         AHB master inputs
module mipsfpga_ahb_dma #(
   parameter int          LEN_W     = 16,
   parameter int unsigned LOCK_XFER = 0
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [31:0]      HADDR,
   output logic [2:0]       HBURST,
   output logic [3:0]       HPROT,
   output logic [2:0]       HSIZE,
   output logic [1:0]       HTRANS,
   output logic [31:0]      HWDATA,
   output logic             HWRITE,
   output logic             HBUSREQ,
   output logic             HLOCK,
   input  logic             HGRANT,
   input  logic [31:0]      HRDATA,
   input  logic             HREADY,
   input  logic             HRESP
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REQ  = 3'd1;
   localparam logic [2:0] S_RD_A = 3'd2;
   localparam logic [2:0] S_RD_D = 3'd3;
   localparam logic [2:0] S_WR_A = 3'd4;
   localparam logic [2:0] S_WR_D = 3'd5;
   localparam logic [2:0] S_FIN  = 3'd6;

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;

   logic [2:0]       state;
   logic             own;
   logic             wr_pending;
   logic [31:0]      src;
   logic [31:0]      dst;
   logic [31:0]      wbuf;
   logic [LEN_W-1:0] cnt;

   // Ownership only changes when the previous transfer on the bus completes.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         own <= 1'b0;
      end else if (HREADY) begin
         own <= HGRANT;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state      <= S_IDLE;
         wr_pending <= 1'b0;
         src        <= 32'd0;
         dst        <= 32'd0;
         wbuf       <= 32'd0;
         cnt        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         HBUSREQ    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  src        <= src_addr;
                  dst        <= dst_addr;
                  cnt        <= len;
                  error      <= 1'b0;
                  wr_pending <= 1'b0;
                  if (len == '0) begin
                     state <= S_FIN;
                     done  <= 1'b1;
                  end else begin
                     state   <= S_REQ;
                     busy    <= 1'b1;
                     HBUSREQ <= 1'b1;
                  end
               end
            end
            // Resume where the copy was interrupted: a pending write must
            // not re-read the source word.
            S_REQ: begin
               if (own) begin
                  state <= wr_pending ? S_WR_A : S_RD_A;
               end
            end
            S_RD_A: begin
               if (!own) begin
                  state      <= S_REQ;
                  wr_pending <= 1'b0;
               end else if (HREADY) begin
                  state <= S_RD_D;
               end
            end
            // An ERROR is acted on in its first (HREADY=0) cycle so that no
            // new transfer can follow it.
            S_RD_D: begin
               if (HRESP) begin
                  state   <= S_FIN;
                  error   <= 1'b1;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  HBUSREQ <= 1'b0;
               end else if (HREADY) begin
                  wbuf  <= HRDATA;
                  state <= S_WR_A;
               end
            end
            S_WR_A: begin
               if (!own) begin
                  state      <= S_REQ;
                  wr_pending <= 1'b1;
               end else if (HREADY) begin
                  state <= S_WR_D;
               end
            end
            S_WR_D: begin
               if (HRESP) begin
                  state   <= S_FIN;
                  error   <= 1'b1;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  HBUSREQ <= 1'b0;
               end else if (HREADY) begin
                  src        <= src + 32'd4;
                  dst        <= dst + 32'd4;
                  cnt        <= cnt - LEN_W'(1);
                  wr_pending <= 1'b0;
                  if (cnt == LEN_W'(1)) begin
                     state   <= S_FIN;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     HBUSREQ <= 1'b0;
                  end else begin
                     state <= own ? S_RD_A : S_REQ;
                  end
               end
            end
            S_FIN: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign HTRANS = (own && ((state == S_RD_A) || (state == S_WR_A))) ? TR_NONSEQ : TR_IDLE;
   assign HADDR  = (state == S_WR_A) ? dst : src;
   assign HWRITE = (state == S_WR_A);
   assign HWDATA = wbuf;
   assign HLOCK  = (LOCK_XFER != 0) ? HBUSREQ : 1'b0;
   assign HBURST = 3'b000;
   assign HPROT  = 4'b0011;
   assign HSIZE  = 3'b010;

endmodule

// File: tb/tb_mipsfpga_ahb_dma.sv
module tb_mipsfpga_ahb_dma;

   logic        HCLK    = 1'b0;
   logic        HRESETn = 1'b0;
   logic        start   = 1'b0;
   logic [31:0] src_addr = 32'd0;
   logic [31:0] dst_addr = 32'd0;
   logic [15:0] len      = 16'd0;
   logic        busy, done, error;
   logic [31:0] HADDR, HWDATA;
   logic [2:0]  HBURST, HSIZE;
   logic [3:0]  HPROT;
   logic [1:0]  HTRANS;
   logic        HWRITE, HBUSREQ, HLOCK;
   logic        HGRANT = 1'b1;
   logic [31:0] HRDATA = 32'd0;
   logic        HREADY = 1'b1;
   logic        HRESP  = 1'b0;

   mipsfpga_ahb_dma #(.LEN_W(16), .LOCK_XFER(0)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .src_addr(src_addr),
      .dst_addr(dst_addr), .len(len), .busy(busy), .done(done), .error(error),
      .HADDR(HADDR), .HBURST(HBURST), .HPROT(HPROT), .HSIZE(HSIZE),
      .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE), .HBUSREQ(HBUSREQ),
      .HLOCK(HLOCK), .HGRANT(HGRANT), .HRDATA(HRDATA), .HREADY(HREADY),
      .HRESP(HRESP)
   );

   always #5 HCLK = ~HCLK;

   int cyc = 0;
   always @(posedge HCLK) cyc <= cyc + 1;

   // knobs written only by the stimulus block
   int wait_knob  = 0;
   int err_rd_idx = 0;

   // observations written only by the responder
   logic [31:0] rd_addr[$];
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   int          ns_cyc[$];
   int          done_cyc[$];
   int          ns_in_err   = 0;
   int          bad_nonseq  = 0;
   int          hw_unstable = 0;
   logic        req_at_done = 1'b1;

   int n_cmp = 0;
   int n_err = 0;

   // Single-slave responder: decides HREADY/HRESP/HRDATA half a cycle
   // before each rising edge and records what the master puts on the bus.
   initial begin : responder
      logic        dp_active, dp_write, dp_err, dp_first, err_stage;
      logic        own_m, own_nx;
      logic [31:0] dp_addr, dp_wdata;
      int          dp_wait;
      dp_active = 0; dp_write = 0; dp_err = 0; dp_first = 0; err_stage = 0;
      own_m = 0; own_nx = 0; dp_addr = 0; dp_wdata = 0; dp_wait = 0;
      forever begin
         @(negedge HCLK);
         if (!HRESETn) begin
            dp_active = 0; err_stage = 0; own_m = 0; own_nx = 0;
            HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'd0;
         end else begin
            own_m = own_nx;
            if (dp_active && dp_wait > 0) begin
               HREADY = 1'b0; HRESP = 1'b0; dp_wait--;
            end else if (dp_active && dp_err && !err_stage) begin
               HREADY = 1'b0; HRESP = 1'b1; err_stage = 1;
            end else if (dp_active && dp_err) begin
               HREADY = 1'b1; HRESP = 1'b1; err_stage = 0;
            end else begin
               HREADY = 1'b1; HRESP = 1'b0;
            end
            HRDATA = (dp_active && HREADY && !HRESP) ? (dp_addr ^ 32'h5A5A_0000) : 32'hDEAD_BEEF;
            if (dp_active && dp_write) begin
               if (dp_first) dp_wdata = HWDATA;
               else if (HWDATA !== dp_wdata) hw_unstable++;
            end
            dp_first = 0;
            if (HRESP && HTRANS == 2'b10) ns_in_err++;
            if (HTRANS == 2'b10 && !own_m) bad_nonseq++;
            if (HTRANS == 2'b10) ns_cyc.push_back(cyc);
            if (done) begin done_cyc.push_back(cyc); req_at_done = HBUSREQ; end
            if (HREADY) begin
               if (dp_active && dp_write && !dp_err) wr_data.push_back(HWDATA);
               dp_active = 0;
               if (HTRANS == 2'b10) begin
                  dp_active = 1; dp_addr = HADDR; dp_write = HWRITE;
                  dp_wait = wait_knob; dp_first = 1;
                  if (HWRITE) wr_addr.push_back(HADDR);
                  else rd_addr.push_back(HADDR);
                  dp_err = !HWRITE && (rd_addr.size() == err_rd_idx);
               end
            end
            own_nx = HREADY ? HGRANT : own_m;
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
      @(posedge HCLK); #1;
      src_addr = s; dst_addr = d; len = n; start = 1'b1;
      @(posedge HCLK); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int base, input int budget, input string tag);
      int i = 0;
      while (done_cyc.size() == base && i < budget) begin
         @(posedge HCLK); #1;
         i++;
      end
      chk(tag, 32'(done_cyc.size() > base), 32'd1);
   endtask

   int rb, wb, db, nb;

   task automatic mark();
      rb = rd_addr.size(); wb = wr_addr.size(); db = done_cyc.size(); nb = ns_cyc.size();
   endtask

   initial begin : stimulus
      // reset values
      repeat (2) @(posedge HCLK);
      #1;
      chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
      chk("rst_error", error, 0);     chk("rst_busreq", HBUSREQ, 0);
      chk("rst_lock", HLOCK, 0);      chk("rst_htrans", HTRANS, 0);
      chk("rst_hwrite", HWRITE, 0);   chk("rst_haddr", HADDR, 0);
      chk("rst_hwdata", HWDATA, 0);   chk("hburst", HBURST, 3'b000);
      chk("hprot", HPROT, 4'b0011);   chk("hsize", HSIZE, 3'b010);
      HRESETn = 1'b1;
      repeat (2) @(posedge HCLK);

      // zero-wait copy of three words
      mark();
      kick(32'h100, 32'h200, 16'd3);
      chk("t1_busy", busy, 1); chk("t1_busreq", HBUSREQ, 1); chk("t1_lock", HLOCK, 0);
      wait_done(db, 40, "t1_done_seen");
      repeat (3) @(posedge HCLK);
      #1;
      chk("t1_rd_n", rd_addr.size() - rb, 3);   chk("t1_wr_n", wr_addr.size() - wb, 3);
      chk("t1_rd0", rd_addr[rb], 32'h100);      chk("t1_rd1", rd_addr[rb+1], 32'h104);
      chk("t1_rd2", rd_addr[rb+2], 32'h108);
      chk("t1_wr0", wr_addr[wb], 32'h200);      chk("t1_wr1", wr_addr[wb+1], 32'h204);
      chk("t1_wr2", wr_addr[wb+2], 32'h208);
      chk("t1_wd0", wr_data[wb], 32'h5A5A0100); chk("t1_wd1", wr_data[wb+1], 32'h5A5A0104);
      chk("t1_wd2", wr_data[wb+2], 32'h5A5A0108);
      chk("t1_done_n", done_cyc.size() - db, 1);
      chk("t1_latency", done_cyc[db] - ns_cyc[nb], 12);
      chk("t1_error", error, 0); chk("t1_busy_end", busy, 0); chk("t1_busreq_end", HBUSREQ, 0);

      // two wait states in each data phase
      wait_knob = 2;
      mark();
      kick(32'h300, 32'h400, 16'd1);
      wait_done(db, 40, "t2_done_seen");
      repeat (3) @(posedge HCLK);
      #1;
      wait_knob = 0;
      chk("t2_rd_n", rd_addr.size() - rb, 1);   chk("t2_wr_n", wr_addr.size() - wb, 1);
      chk("t2_wd0", wr_data[wb], 32'h5A5A0300); chk("t2_hw_stable", hw_unstable, 0);
      chk("t2_latency", done_cyc[db] - ns_cyc[nb], 8);
      chk("t2_done_n", done_cyc.size() - db, 1);

      // grant lost while the write address is due
      mark();
      kick(32'h500, 32'h600, 16'd1);
      for (int i = 0; i < 20 && rd_addr.size() == rb; i++) begin
         @(posedge HCLK); #1;
      end
      HGRANT = 1'b0;
      repeat (3) @(posedge HCLK);
      #1;
      chk("t3_idle_htrans", HTRANS, 2'b00); chk("t3_busreq", HBUSREQ, 1);
      chk("t3_busy", busy, 1);              chk("t3_no_wr_yet", wr_addr.size() - wb, 0);
      repeat (2) @(posedge HCLK);
      #1;
      HGRANT = 1'b1;
      wait_done(db, 40, "t3_done_seen");
      repeat (2) @(posedge HCLK);
      #1;
      chk("t3_rd_n", rd_addr.size() - rb, 1);   chk("t3_wr_n", wr_addr.size() - wb, 1);
      chk("t3_wr0", wr_addr[wb], 32'h600);      chk("t3_wd0", wr_data[wb], 32'h5A5A0500);
      chk("t3_owned_nonseq", bad_nonseq, 0);

      // ERROR response on the second read
      mark();
      err_rd_idx = rb + 2;
      kick(32'h700, 32'h800, 16'd4);
      wait_done(db, 40, "t4_done_seen");
      repeat (5) @(posedge HCLK);
      #1;
      err_rd_idx = 0;
      chk("t4_error", error, 1);               chk("t4_done_n", done_cyc.size() - db, 1);
      chk("t4_rd_n", rd_addr.size() - rb, 2);  chk("t4_wr_n", wr_addr.size() - wb, 1);
      chk("t4_idle_in_err", ns_in_err, 0);     chk("t4_req_at_done", req_at_done, 0);
      chk("t4_busreq", HBUSREQ, 0);            chk("t4_busy", busy, 0);

      // len=0: immediate done, no request, error cleared
      mark();
      kick(32'h0, 32'h0, 16'd0);
      chk("t5_done", done, 1);   chk("t5_busreq", HBUSREQ, 0);
      chk("t5_busy", busy, 0);   chk("t5_err_clr", error, 0);
      @(posedge HCLK); #1;
      chk("t5_done_pulse", done, 0);

      // start while busy is ignored
      mark();
      kick(32'h900, 32'hA00, 16'd2);
      repeat (3) @(posedge HCLK);
      #1;
      src_addr = 32'hB00; dst_addr = 32'hC00; len = 16'd5; start = 1'b1;
      @(posedge HCLK); #1;
      start = 1'b0;
      wait_done(db, 40, "t6_done_seen");
      repeat (4) @(posedge HCLK);
      #1;
      chk("t6_rd_n", rd_addr.size() - rb, 2);  chk("t6_rd1", rd_addr[rb+1], 32'h904);
      chk("t6_wr1", wr_addr[wb+1], 32'hA04);   chk("t6_done_n", done_cyc.size() - db, 1);
      chk("t6_busy", busy, 0);

      // source address wraps past 2^32
      mark();
      kick(32'hFFFF_FFFC, 32'h1000, 16'd2);
      wait_done(db, 40, "t7_done_seen");
      repeat (2) @(posedge HCLK);
      #1;
      chk("t7_rd0", rd_addr[rb], 32'hFFFF_FFFC); chk("t7_rd1", rd_addr[rb+1], 32'h0);
      chk("t7_wd0", wr_data[wb], 32'hA5A5_FFFC); chk("t7_wd1", wr_data[wb+1], 32'h5A5A_0000);
      chk("t7_wr1", wr_addr[wb+1], 32'h1004);

      // asynchronous reset in the middle of a write data phase
      mark();
      kick(32'h2000, 32'h3000, 16'd2);
      for (int i = 0; i < 20 && wr_addr.size() == wb; i++) begin
         @(posedge HCLK); #1;
      end
      chk("t8_pre_busreq", HBUSREQ, 1); chk("t8_pre_hwdata", HWDATA, 32'h5A5A2000);
      #1;
      HRESETn = 1'b0;
      #1;
      chk("t8_busy", busy, 0);     chk("t8_busreq", HBUSREQ, 0);
      chk("t8_htrans", HTRANS, 0); chk("t8_hwdata", HWDATA, 0);
      repeat (2) @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      repeat (5) @(posedge HCLK);
      #1;
      chk("t8_no_done", done_cyc.size() - db, 0); chk("t8_idle_busy", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
